child_rr_scheduler: RTL and testbench
=====================================

// Module: child_rr_scheduler
// PURPOSE
//  Round-robin scheduler sharing one downstream resource (bus/port) among the N child instances of a root module.
//  Sits in the root module beside the child instances; each child raises req, receives a one-hot grant, and holds it until done/drop or a hold timeout.
//  Guarantees fairness (no starvation) and bounded tenure per child.
// PARAMETERS
//  NUM_REQ   5    number of requesting child instances (>=2)
//  MAX_HOLD  16   max consecutive GRANT cycles before forced release (>=2)
//  CNT_W     16   width of the saturating grant counter
// PORTS
//  clk          in   1                      single clock, rising edge
//  rst          in   1                      asynchronous, active-high reset
//  enable       in   1                      1 = new grants allowed
//  req          in   NUM_REQ                level request per child
//  done         in   NUM_REQ                1-cycle completion pulse per child; only the holder's bit is honoured
//  gnt          out  NUM_REQ                one-hot grant, all-zero when none
//  gnt_valid    out  1                      |gnt
//  gnt_id       out  $clog2(NUM_REQ)        index of holder, 0 when none
//  timeout      out  1                      1-cycle pulse on forced release
//  timeout_id   out  $clog2(NUM_REQ)        holder index at timeout, held until next timeout
//  grant_cnt    out  CNT_W                  total grants issued, saturates at all-ones
// BEHAVIOUR
//  Reset (async assert, sync release): state=IDLE, ptr=0, hold_cnt=0; all outputs 0.
//  FSM states: IDLE, GRANT, GAP.
//  IDLE: if enable && |req, pick first set req at index ptr, ptr+1, ... wrapping NUM_REQ-1 -> 0.
//   gnt registered: req sampled at edge t -> gnt high after edge t+1 (1-cycle latency). -> GRANT, hold_cnt=1, grant_cnt++.
//  GRANT: holder h keeps gnt while req[h]=1 and done[h]=0 and hold_cnt<MAX_HOLD; hold_cnt++ each cycle.
//   Release (req[h]=0 or done[h]=1): -> GAP, ptr=(h+1) mod NUM_REQ.
//   Forced (hold_cnt==MAX_HOLD, no release): -> GAP, timeout=1 for one cycle, timeout_id=h, ptr=(h+1) mod NUM_REQ.
//   Release and hold limit in the same cycle: normal release, no timeout pulse.
//   done/req bits of non-holders ignored; enable going low does not revoke current grant.
//  GAP: gnt=0 for exactly one cycle (bus turnaround), then -> IDLE; arbitration resumes from IDLE on the next edge.
//  Hence back-to-back tenures are separated by 2 idle-grant cycles (GAP + IDLE decision).
//  A timed-out child still requesting is re-eligible but only after all other requesters in round-robin order.
//  No req while IDLE or enable=0: stay IDLE, outputs 0, ptr unchanged.
//  grant_cnt saturates at 2^CNT_W-1, never wraps.
//  Reset asserted mid-tenure: gnt drops immediately (async), ptr returns to 0.
//  Invariant: $onehot0(gnt) every cycle; gnt_valid == |gnt; gnt_id consistent with gnt.
// STRUCTURE
//  Package child_sched_pkg: typedef enum logic [1:0] {IDLE, GRANT, GAP} sched_state_e; constants for default NUM_REQ/MAX_HOLD.
//  Sub-module rr_pick (combinational): inputs req, ptr; outputs one-hot pick and its index; rotate-priority-encode.
//  Top: FSM, ptr/hold_cnt/grant_cnt registers, output registers.
// TESTING
//  1 Reset, req=5'b00000 for 10 cycles -> gnt=0, gnt_valid=0, grant_cnt=0.
//  2 req=5'b10110 held, done pulsed 3 cycles into each grant -> grant order 1,2,4,1; grant_cnt=4; one GAP cycle between tenures.
//  3 req[3] held high, done never -> gnt=5'b01000 exactly 16 cycles, timeout pulse, timeout_id=3, then regranted to 3 after GAP+IDLE.
//  4 Holder 4 releases, req=5'b00011 -> ptr wraps to 0, next gnt=5'b00001.
//  5 enable=0 during grant of 2 -> grant completes; no new grant until enable=1.
//  6 Async rst mid-GRANT of 2 -> gnt=0 same cycle; after release req=5'b00100 -> gnt=5'b00100 next cycle; hold_cnt=MAX_HOLD with done -> no timeout.

Source files
------------

// File: rtl/child_sched_pkg.sv
// child_sched_pkg: shared state encoding and default sizing for the child round-robin scheduler
package child_sched_pkg;
  typedef enum logic [1:0] {IDLE, GRANT, GAP} sched_state_e;
  localparam int DEF_NUM_REQ = 5;
  localparam int DEF_MAX_HOLD = 16;
  localparam int DEF_CNT_W = 16;
endpackage

// File: rtl/rr_pick.sv
// rr_pick: rotating priority encoder, first set req at ptr, ptr+1, ... wrapping
module rr_pick #(
  parameter int N = 5,
  localparam int IW = $clog2(N)
) (
  input  logic [N-1:0]  req,
  input  logic [IW-1:0] ptr,
  output logic [N-1:0]  pick,
  output logic [IW-1:0] pick_id
);
  int j;
  // scan from lowest priority up so the last hit is the winner
  always_comb begin
    pick = '0;
    pick_id = '0;
    j = 0;
    for (int i = N - 1; i >= 0; i--) begin
      j = int'(ptr) + i;
      j = j >= N ? j - N : j;
      if (req[IW'(j)]) begin
        pick = '0;
        pick[IW'(j)] = 1'b1;
        pick_id = IW'(j);
      end
    end
  end
endmodule

// File: rtl/child_rr_scheduler.sv
// child_rr_scheduler: round-robin grant of one shared resource among child instances with bounded tenure
module child_rr_scheduler
  import child_sched_pkg::*;
#(
  parameter int NUM_REQ = DEF_NUM_REQ,
  parameter int MAX_HOLD = DEF_MAX_HOLD,
  parameter int CNT_W = DEF_CNT_W,
  localparam int IW = $clog2(NUM_REQ),
  localparam int HW = $clog2(MAX_HOLD + 1)
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               enable,
  input  logic [NUM_REQ-1:0] req,
  input  logic [NUM_REQ-1:0] done,
  output logic [NUM_REQ-1:0] gnt,
  output logic               gnt_valid,
  output logic [IW-1:0]      gnt_id,
  output logic               timeout,
  output logic [IW-1:0]      timeout_id,
  output logic [CNT_W-1:0]   grant_cnt
);
  sched_state_e state;
  logic [IW-1:0] ptr;
  logic [HW-1:0] hold_cnt;
  logic [NUM_REQ-1:0] pick;
  logic [IW-1:0] pick_id;
  logic rel;
  logic [IW-1:0] nxt;

  rr_pick #(.N(NUM_REQ)) u_pick (.req(req), .ptr(ptr), .pick(pick), .pick_id(pick_id));

  // gnt is one-hot, so this is req[h]==0 || done[h]==1 for the holder only
  assign rel = |(gnt & (~req | done));
  assign nxt = gnt_id == IW'(NUM_REQ - 1) ? '0 : gnt_id + 1'b1;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      ptr <= '0;
      hold_cnt <= '0;
      gnt <= '0;
      gnt_valid <= 1'b0;
      gnt_id <= '0;
      timeout <= 1'b0;
      timeout_id <= '0;
      grant_cnt <= '0;
    end else begin
      timeout <= 1'b0;
      case (state)
        IDLE: if (enable && |req) begin
          state <= GRANT;
          gnt <= pick;
          gnt_valid <= 1'b1;
          gnt_id <= pick_id;
          hold_cnt <= HW'(1);
          grant_cnt <= &grant_cnt ? grant_cnt : grant_cnt + CNT_W'(1);
        end
        GRANT: if (rel || hold_cnt == HW'(MAX_HOLD)) begin
          state <= GAP;
          gnt <= '0;
          gnt_valid <= 1'b0;
          gnt_id <= '0;
          hold_cnt <= '0;
          ptr <= nxt;
          timeout <= !rel;
          if (!rel) timeout_id <= gnt_id;
        end else hold_cnt <= hold_cnt + 1'b1;
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_child_rr_scheduler.sv
// tb_child_rr_scheduler: directed checks of grant order, timeout, wrap, enable gating and async reset
module tb_child_rr_scheduler;
  logic clk = 1'b0;
  logic rst, enable;
  logic [4:0] req, done, gnt;
  logic gnt_valid, timeout;
  logic [2:0] gnt_id, timeout_id;
  logic [15:0] grant_cnt;
  int tests = 0;
  int fails = 0;
  int n;

  child_rr_scheduler dut (
    .clk(clk), .rst(rst), .enable(enable), .req(req), .done(done),
    .gnt(gnt), .gnt_valid(gnt_valid), .gnt_id(gnt_id),
    .timeout(timeout), .timeout_id(timeout_id), .grant_cnt(grant_cnt)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    chk("inv_onehot_valid", {30'd0, $onehot0(gnt), gnt_valid == |gnt}, 32'd3);
  endtask

  task automatic tenure(input logic [4:0] g, input logic [2:0] id, input logic [15:0] cnt);
    chk("ten_gnt", gnt, g);
    chk("ten_id", gnt_id, id);
    chk("ten_cnt", grant_cnt, cnt);
    tick();
    chk("ten_hold", gnt, g);
    tick();
    done = g;
    tick();
    done = '0;
    chk("ten_gap", gnt, 0);
    tick();
    chk("ten_idle", gnt, 0);
  endtask

  initial begin
    rst = 1'b1; enable = 1'b0; req = '0; done = '0;
    #3;
    chk("rst_gnt", gnt, 0);
    chk("rst_cnt", grant_cnt, 0);
    tick(); tick();
    rst = 1'b0;
    // 1: idle with no requests
    enable = 1'b1;
    repeat (10) tick();
    chk("t1_gnt", gnt, 0);
    chk("t1_valid", gnt_valid, 0);
    chk("t1_cnt", grant_cnt, 0);
    // 2: round-robin order 1,2,4,1
    req = 5'b10110;
    tick(); tenure(5'b00010, 3'd1, 16'd1);
    tick(); tenure(5'b00100, 3'd2, 16'd2);
    tick(); tenure(5'b10000, 3'd4, 16'd3);
    tick(); tenure(5'b00010, 3'd1, 16'd4);
    // 3: hold timeout of child 3
    req = 5'b01000;
    tick();
    chk("t3_gnt", gnt, 5'b01000);
    chk("t3_cnt", grant_cnt, 5);
    n = 1;
    for (int i = 0; i < 40; i++) begin
      tick();
      if (gnt != 5'b01000) break;
      n++;
    end
    chk("t3_len", n, 16);
    chk("t3_to", timeout, 1);
    chk("t3_toid", timeout_id, 3);
    tick();
    chk("t3_to_pulse", timeout, 0);
    chk("t3_idle", gnt, 0);
    chk("t3_toid_hold", timeout_id, 3);
    tick();
    chk("t3_regnt", gnt, 5'b01000);
    chk("t3_cnt2", grant_cnt, 6);
    // 4: holder 4 releases, pointer wraps to 0
    req = 5'b10000;
    tick(); tick(); tick();
    chk("t4_gnt4", gnt, 5'b10000);
    chk("t4_id4", gnt_id, 4);
    req = 5'b00011;
    tick();
    chk("t4_gap", gnt, 0);
    tick(); tick();
    chk("t4_wrap", gnt, 5'b00001);
    chk("t4_id0", gnt_id, 0);
    chk("t4_cnt", grant_cnt, 8);
    // 5: enable low does not revoke, blocks new grants
    req = 5'b00100;
    tick(); tick(); tick();
    chk("t5_gnt2", gnt, 5'b00100);
    enable = 1'b0;
    tick();
    chk("t5_kept", gnt, 5'b00100);
    done = 5'b00100;
    tick();
    done = '0;
    chk("t5_rel", gnt, 0);
    repeat (4) tick();
    chk("t5_blocked", gnt, 0);
    chk("t5_cnt", grant_cnt, 9);
    enable = 1'b1;
    tick();
    chk("t5_regnt", gnt, 5'b00100);
    chk("t5_cnt2", grant_cnt, 10);
    // 6: async reset mid-grant, then release and hold limit together
    tick();
    #2 rst = 1'b1;
    #1;
    chk("t6_async_gnt", gnt, 0);
    chk("t6_async_valid", gnt_valid, 0);
    chk("t6_async_cnt", grant_cnt, 0);
    @(posedge clk); #1;
    rst = 1'b0;
    tick();
    chk("t6_gnt", gnt, 5'b00100);
    chk("t6_cnt", grant_cnt, 1);
    repeat (15) tick();
    chk("t6_hold16", gnt, 5'b00100);
    done = 5'b00100;
    tick();
    done = '0;
    chk("t6_rel", gnt, 0);
    chk("t6_no_to", timeout, 0);
    chk("t6_toid", timeout_id, 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
